// File: rtl/demo_note_sequencer_pkg.sv
// piano_demo_pkg: shared note type, mode code, FSM states and default demo melody
// Contents: note_t {key[4:0], dur[3:0]}, DEMO_MODE, KEY_COUNT, demo_state_t, DEMO_SONG
package piano_demo_pkg;
    typedef struct packed {
        logic [4:0] key;
        logic [3:0] dur;
    } note_t;
    localparam logic [7:0] DEMO_MODE = 8'd17;
    localparam int KEY_COUNT = 16;
    typedef enum logic [2:0] {IDLE, LOAD, NOTE, GAP, DONE} demo_state_t;
    localparam note_t DEMO_SONG [32] = '{
        '{5'd1, 4'd1}, '{5'd1, 4'd1}, '{5'd8, 4'd1}, '{5'd8, 4'd1},
        '{5'd10, 4'd1}, '{5'd10, 4'd1}, '{5'd8, 4'd2}, '{5'd6, 4'd1},
        '{5'd6, 4'd1}, '{5'd5, 4'd1}, '{5'd5, 4'd1}, '{5'd3, 4'd1},
        '{5'd3, 4'd1}, '{5'd1, 4'd2}, '{5'd8, 4'd1}, '{5'd8, 4'd1},
        '{5'd6, 4'd1}, '{5'd6, 4'd1}, '{5'd5, 4'd1}, '{5'd5, 4'd1},
        '{5'd3, 4'd2}, '{5'd8, 4'd1}, '{5'd8, 4'd1}, '{5'd6, 4'd1},
        '{5'd6, 4'd1}, '{5'd5, 4'd1}, '{5'd5, 4'd1}, '{5'd3, 4'd2},
        '{5'd0, 4'd2}, '{5'd1, 4'd4}, '{5'd0, 4'd1}, '{5'd0, 4'd0}
    };
endpackage

// File: rtl/demo_note_sequencer_rom.sv
// demo_song_rom: combinational note table lookup with illegal-key squashing and end detection
// Ports: addr (table index) -> key (0 for rest/illegal), dur, is_end (dur==0 or addr past table)
module demo_song_rom
    import piano_demo_pkg::*;
#(
    parameter int SONG_LEN = 32,
    parameter int AW = 5,
    parameter note_t SONG [SONG_LEN] = DEMO_SONG
) (
    input  logic [AW-1:0] addr,
    output logic [4:0]    key,
    output logic [3:0]    dur,
    output logic          is_end
);
    note_t entry;
    always_comb begin
        entry = (32'(addr) < SONG_LEN) ? SONG[addr] : '0;
        key = (entry.key > 5'(KEY_COUNT)) ? 5'd0 : entry.key;
        dur = entry.dur;
        is_end = entry.dur == 4'd0;
    end
endmodule

// File: rtl/demo_note_sequencer.sv
// demo_note_sequencer: steps through a note table driving audio_demo with key indices and gaps
// Ports: clk50, reset_n (async low), mode_select (demo when == DEMO_MODE), pause (freeze),
//        audio_demo (key 1..16, 0 silent), note_idx (entry playing), playing, song_done
module demo_note_sequencer
    import piano_demo_pkg::*;
#(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES = 1_250_000,
    parameter int SONG_LEN = 32,
    parameter bit LOOP = 1'b1,
    parameter note_t SONG [SONG_LEN] = DEMO_SONG,
    localparam int IW = SONG_LEN > 1 ? $clog2(SONG_LEN) : 1
) (
    input  logic          clk50,
    input  logic          reset_n,
    input  logic [7:0]    mode_select,
    input  logic          pause,
    output logic [7:0]    audio_demo,
    output logic [IW-1:0] note_idx,
    output logic          playing,
    output logic          song_done
);
    localparam int CW = $clog2(15 * BEAT_CYCLES + 1);
    localparam logic [CW-1:0] BEAT = CW'(BEAT_CYCLES);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(SONG_LEN - 1);
    demo_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [IW-1:0] idx_nxt;
    logic [7:0] audio_nxt;
    logic at_end, at_end_nxt;
    logic [4:0] key;
    logic [3:0] dur;
    logic is_end;
    logic demo_en;
    demo_song_rom #(.SONG_LEN(SONG_LEN), .AW(IW), .SONG(SONG)) u_rom (
        .addr(note_idx),
        .key(key),
        .dur(dur),
        .is_end(is_end)
    );
    assign demo_en = mode_select == DEMO_MODE;
    // at_end marks a LOAD reached by running off the table, so it behaves like an end marker
    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt;
        idx_nxt = note_idx;
        audio_nxt = audio_demo;
        at_end_nxt = at_end;
        if (!demo_en) begin
            state_nxt = IDLE;
            cnt_nxt = '0;
            idx_nxt = '0;
            audio_nxt = '0;
            at_end_nxt = 1'b0;
        end else if (!pause) begin
            case (state)
                IDLE: state_nxt = LOAD;
                LOAD: begin
                    if (is_end || at_end) begin
                        at_end_nxt = 1'b0;
                        idx_nxt = LOOP ? '0 : note_idx;
                        state_nxt = LOOP ? LOAD : DONE;
                    end else begin
                        state_nxt = NOTE;
                        audio_nxt = {3'b000, key};
                        cnt_nxt = CW'(dur) * BEAT - CW'(1);
                    end
                end
                NOTE: begin
                    state_nxt = cnt == '0 ? GAP : NOTE;
                    audio_nxt = cnt == '0 ? 8'd0 : audio_demo;
                    cnt_nxt = cnt == '0 ? GAP_LOAD : cnt - 1'b1;
                end
                GAP: begin
                    state_nxt = cnt == '0 ? LOAD : GAP;
                    cnt_nxt = cnt == '0 ? cnt : cnt - 1'b1;
                    idx_nxt = cnt != '0 ? note_idx : note_idx == LAST_IDX ? '0 : note_idx + 1'b1;
                    at_end_nxt = cnt == '0 && note_idx == LAST_IDX;
                end
                DONE: state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            note_idx <= '0;
            audio_demo <= '0;
            at_end <= 1'b0;
            playing <= 1'b0;
            song_done <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            note_idx <= idx_nxt;
            audio_demo <= audio_nxt;
            at_end <= at_end_nxt;
            playing <= state_nxt inside {LOAD, NOTE, GAP};
            song_done <= state_nxt == DONE;
        end
    end
endmodule
